// File: rtl/audio_mixer_sd.sv
// audio_mixer_sd: NCH-channel stereo mixer with per-channel left/right gain,
// one shared multiply-accumulate per side, output saturation and a
// first-order sigma-delta DAC per side.
module audio_mixer_sd #(
   parameter int NCH = 4,
   parameter int IW  = 8,
   parameter int GW  = 4,
   parameter int OW  = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NCH*IW-1:0]         ch_in,
   input  logic                      sample_en,
   input  logic                      gain_we,
   input  logic [$clog2(2*NCH)-1:0]  gain_addr,
   input  logic [GW-1:0]             gain_data,
   output logic                      audio_left,
   output logic                      audio_right,
   output logic [OW-1:0]             level_l,
   output logic [OW-1:0]             level_r,
   output logic                      busy,
   output logic                      clip_l,
   output logic                      clip_r,
   output logic                      overrun
);

   // Accumulator is sized so that NCH full-scale products can never wrap.
   localparam int AW  = IW + GW + $clog2(NCH);
   localparam int IXW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int NG  = 2 * NCH;
   localparam int CW  = (AW > OW + 1) ? AW : OW + 1;
   localparam logic [GW-1:0] UNITY = GW'(1 << (GW - 1));
   localparam logic [CW-1:0] MAXL  = CW'((64'd1 << OW) - 64'd1);

   typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [GW-1:0]     gain [NG];
   logic [IW-1:0]     smp  [NCH];
   logic [GW-1:0]     gsl  [NCH];
   logic [GW-1:0]     gsr  [NCH];
   logic [AW-1:0]     acc_l;
   logic [AW-1:0]     acc_r;
   logic [IXW-1:0]    idx;
   logic [OW-1:0]     dac_l;
   logic [OW-1:0]     dac_r;
   logic [OW:0]       sum_l;
   logic [OW:0]       sum_r;
   logic              accept;

   // One channel's contribution, widened so the product fits unchanged.
   function automatic logic [AW-1:0] mac(input logic [IW-1:0] s, input logic [GW-1:0] g);
      return AW'(s) * AW'(g);
   endfunction

   // Drop the unity-gain fraction bits, then clamp to full-scale DAC level.
   function automatic logic [OW-1:0] sat_level(input logic [AW-1:0] a);
      logic [CW-1:0] m;
      m = CW'(a >> (GW - 1));
      return (m > MAXL) ? MAXL[OW-1:0] : m[OW-1:0];
   endfunction

   function automatic logic is_clip(input logic [AW-1:0] a);
      logic [CW-1:0] m;
      m = CW'(a >> (GW - 1));
      return (m > MAXL);
   endfunction

   assign accept = (state == IDLE) && sample_en;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state logic: IDLE -> ACC (NCH cycles) -> SAT (1 cycle) -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sample_en) state_nxt = ACC;
         ACC:     if (idx == IXW'(NCH - 1)) state_nxt = SAT;
         SAT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state != IDLE);
   end

   // Gain table; writes land in any state, the running mix uses its snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NG; i++) gain[i] <= UNITY;
      end else if (gain_we && (int'(gain_addr) < NG)) begin
         gain[gain_addr] <= gain_data;
      end
   end

   // Snapshot on accept, then one multiply-accumulate per side per cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < NCH; k++) begin
            smp[k] <= ch_in[k*IW +: IW];
            gsl[k] <= gain[2*k];
            gsr[k] <= gain[2*k+1];
         end
         acc_l <= '0;
         acc_r <= '0;
         idx   <= '0;
      end else if (state == ACC) begin
         acc_l <= acc_l + mac(smp[idx], gsl[idx]);
         acc_r <= acc_r + mac(smp[idx], gsr[idx]);
         idx   <= idx + 1'b1;
      end
   end

   // Level update with clip flags in SAT, plus dropped-strobe detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_l <= '0;
         level_r <= '0;
         clip_l  <= 1'b0;
         clip_r  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         clip_l  <= 1'b0;
         clip_r  <= 1'b0;
         overrun <= sample_en && (state != IDLE);
         if (state == SAT) begin
            level_l <= sat_level(acc_l);
            level_r <= sat_level(acc_r);
            clip_l  <= is_clip(acc_l);
            clip_r  <= is_clip(acc_r);
         end
      end
   end

   // Sigma-delta sums: the carry out is the output bit.
   always_comb begin
      sum_l = {1'b0, dac_l} + {1'b0, level_l};
      sum_r = {1'b0, dac_r} + {1'b0, level_r};
   end

   // Sigma-delta accumulators; not cleared on level change, only on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dac_l       <= '0;
         dac_r       <= '0;
         audio_left  <= 1'b0;
         audio_right <= 1'b0;
      end else begin
         dac_l       <= sum_l[OW-1:0];
         dac_r       <= sum_r[OW-1:0];
         audio_left  <= sum_l[OW];
         audio_right <= sum_r[OW];
      end
   end

endmodule
